pipeline_memory_stage: RTL and testbench
========================================

Name: pipeline_memory_stage

Overview:
- MEM-stage access controller. Consumes the EX/MEM latch outputs (m_* signals) and drives the data-cache request interface.
- Holds each request until dhit, captures load/SC data, and raises mem_busy so the hazard unit holds the EX/MEM latch (em_state) until the access completes.
- Also provides a sticky halt flag, a misalignment check and a wait watchdog.

Parameters:
- WAIT_MAX, 255: ACCESS cycles without dhit before the watchdog aborts the access.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- m_dREN  in  1  latch: load (LL if m_datomic).
- m_dWEN  in  1  latch: store (SC if m_datomic).
- m_datomic  in  1  latch: atomic qualifier.
- m_halt  in  1  latch: halt instruction.
- m_port_o  in  32  latch: ALU result, used as the address.
- m_rdat2  in  32  latch: store data.
- pipe_advance  in  1  MEM/WB accepts this cycle, so the EX/MEM latch reloads next edge.
- dhit  in  1  cache completes the current request.
- dmemload  in  32  cache read data (SC: 1 = success, 0 = fail).
- dmemREN  out  1  cache read request.
- dmemWEN  out  1  cache write request.
- datomic  out  1  cache atomic qualifier.
- dmemaddr  out  32  request address.
- dmemstore  out  32  request write data.
- m_dload  out  32  captured load/SC result.
- mem_busy  out  1  stall request to the hazard unit.
- halt  out  1  sticky halt.
- align_err  out  1  sticky misaligned-access flag.
- mem_timeout  out  1  sticky watchdog flag.

Behaviour:
- memop = m_dREN | m_dWEN.
- FSM states: IDLE, ACCESS, DONE (mem_state_t).
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state = IDLE, wait counter = 0.
  - Every output = 0: dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, m_dload, mem_busy, halt, align_err, mem_timeout.
  - A request in flight is dropped, with no retry after reset.
- IDLE:
  - If m_halt: set halt next edge; halt stays 1 until RST.
  - If halt is set: issue no requests; memop is ignored and mem_busy = 0.
  - Else if memop and m_port_o[1:0] != 0: no request; set align_err (sticky); clear m_dload; go to DONE.
  - Else if memop: register dmemaddr = m_port_o, dmemstore = m_rdat2, dmemREN = m_dREN, dmemWEN = m_dWEN, datomic = m_datomic; clear the counter; go to ACCESS.
  - If m_dREN and m_dWEN are both 1: treat as a read only.
- ACCESS:
  - Request outputs stay stable every cycle.
  - On dhit: m_dload <= dmemload on a read/LL/SC, unchanged on a plain store; drop all request outputs; go to DONE.
  - Without dhit: counter increments. When the counter reaches WAIT_MAX: set mem_timeout, m_dload <= 0, drop the request, go to DONE.
- DONE:
  - No request; m_dload holds.
  - On pipe_advance go to IDLE; otherwise stay. This guarantees no double issue while downstream stalls.
- mem_busy, registered-equivalent decode:
  - 1 in ACCESS.
  - 1 in IDLE when memop and halt = 0.
  - 0 in DONE.
- Latency: cache with dhit on the first ACCESS cycle gives request at cycle 1, DONE at cycle 2, data valid at cycle 2, and a minimum 3-cycle occupancy per memory instruction.
- Non-memop instructions add no stall.
- pipe_advance while in IDLE or ACCESS is ignored; the hazard unit must honour mem_busy.

Decomposition:
- cpu_types_pkg:
  - add typedef mem_state_t {IDLE, ACCESS, DONE};
  - reuse word_t for 32-bit fields.
- No sub-module; the wait counter is inline.

Test Plan:
1. Load, m_port_o=0x40, dhit on the 2nd ACCESS cycle with dmemload=0xDEADBEEF:
   - dmemREN=1, dmemaddr=0x40 for 2 cycles;
   - m_dload=0xDEADBEEF in DONE;
   - mem_busy 1,1,1 then 0.
2. Store 0x12345678 to 0x80, dhit immediately, pipe_advance held 0 for 3 cycles:
   - exactly one request cycle;
   - stay in DONE with no reissue;
   - IDLE after pipe_advance.
3. SC (m_dWEN=1, m_datomic=1) with dmemload=0 on dhit:
   - datomic=1 during ACCESS;
   - m_dload=0.
4. Load to 0x42:
   - no dmemREN;
   - align_err=1;
   - mem_busy=1 for one cycle, then DONE.
5. dhit never arrives, WAIT_MAX=4:
   - request held 4 ACCESS cycles;
   - mem_timeout=1, m_dload=0, DONE.
6. Async reset mid-ACCESS, and halt:
   - RST mid-ACCESS drops dmemREN in the same cycle; all outputs 0, state IDLE.
   - m_halt then a load: halt=1, no request, mem_busy=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: 32-bit word and the MEM-stage access FSM encoding.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;
endpackage

// File: rtl/pipeline_memory_stage.sv
// MEM-stage data-cache access controller: request registered one cycle after the op is seen, result valid on entry to DONE.
// mem_busy stalls the EX/MEM latch until the access ends; DONE parks until pipe_advance so a stalled op never reissues.
module pipeline_memory_stage
    import cpu_types_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 8
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  m_dREN,
    input  logic  m_dWEN,
    input  logic  m_datomic,
    input  logic  m_halt,
    input  word_t m_port_o,
    input  word_t m_rdat2,
    input  logic  pipe_advance,
    input  logic  dhit,
    input  word_t dmemload,
    output logic  dmemREN,
    output logic  dmemWEN,
    output logic  datomic,
    output word_t dmemaddr,
    output word_t dmemstore,
    output word_t m_dload,
    output logic  mem_busy,
    output logic  halt,
    output logic  align_err,
    output logic  mem_timeout
);

    mem_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_memop;
    logic             w_misal;

    assign w_memop = m_dREN | m_dWEN;
    assign w_misal = (m_port_o[1:0] != 2'b00);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            dmemREN     <= 1'b0;
            dmemWEN     <= 1'b0;
            datomic     <= 1'b0;
            dmemaddr    <= '0;
            dmemstore   <= '0;
            m_dload     <= '0;
            halt        <= 1'b0;
            align_err   <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_halt)
                        halt <= 1'b1;
                    if (!halt && w_memop) begin
                        if (w_misal) begin
                            align_err <= 1'b1;
                            m_dload   <= '0;
                            r_state   <= DONE;
                        end else begin
                            dmemaddr  <= m_port_o;
                            dmemstore <= m_rdat2;
                            dmemREN   <= m_dREN;
                            // A simultaneous read+write request is treated as a read.
                            dmemWEN   <= m_dWEN & ~m_dREN;
                            datomic   <= m_datomic;
                            r_cnt     <= '0;
                            r_state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        // Plain stores leave the previous result; SC returns its status word.
                        if (dmemREN || datomic)
                            m_dload <= dmemload;
                        dmemREN <= 1'b0;
                        dmemWEN <= 1'b0;
                        datomic <= 1'b0;
                        r_state <= DONE;
                    end else if (r_cnt == CNT_W'(WAIT_MAX - 1)) begin
                        mem_timeout <= 1'b1;
                        m_dload     <= '0;
                        dmemREN     <= 1'b0;
                        dmemWEN     <= 1'b0;
                        datomic     <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (pipe_advance)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_busy = 1'b0;
        case (r_state)
            IDLE:    mem_busy = w_memop & ~halt;
            ACCESS:  mem_busy = 1'b1;
            default: mem_busy = 1'b0;
        endcase
        if (RST)
            mem_busy = 1'b0;
    end

endmodule

// File: tb/tb_pipeline_memory_stage.sv
// Self-checking bench for pipeline_memory_stage: directed plan items plus random memory ops against a transaction model.
module tb_pipeline_memory_stage;
    localparam int WAIT_MAX = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        m_dREN = 1'b0, m_dWEN = 1'b0, m_datomic = 1'b0, m_halt = 1'b0;
    logic [31:0] m_port_o = '0, m_rdat2 = '0;
    logic        pipe_advance = 1'b0, dhit = 1'b0;
    logic [31:0] dmemload = '0;
    logic        dmemREN, dmemWEN, datomic, mem_busy, halt, align_err, mem_timeout;
    logic [31:0] dmemaddr, dmemstore, m_dload;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_dload = '0;
    logic        exp_align = 1'b0, exp_timeout = 1'b0, exp_halt = 1'b0;

    pipeline_memory_stage #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .m_dREN(m_dREN), .m_dWEN(m_dWEN), .m_datomic(m_datomic), .m_halt(m_halt),
        .m_port_o(m_port_o), .m_rdat2(m_rdat2), .pipe_advance(pipe_advance),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .m_dload(m_dload),
        .mem_busy(mem_busy), .halt(halt), .align_err(align_err), .mem_timeout(mem_timeout)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ren"}, dmemREN, 0);
        check({tag, "_wen"}, dmemWEN, 0);
        check({tag, "_atomic"}, datomic, 0);
        check({tag, "_addr"}, dmemaddr, 0);
        check({tag, "_store"}, dmemstore, 0);
        check({tag, "_dload"}, m_dload, 0);
        check({tag, "_busy"}, mem_busy, 0);
        check({tag, "_halt"}, halt, 0);
        check({tag, "_align"}, align_err, 0);
        check({tag, "_timeout"}, mem_timeout, 0);
    endtask

    task automatic drive_nop();
        m_dREN = 0; m_dWEN = 0; m_datomic = 0; m_halt = 0;
        m_port_o = $urandom; m_rdat2 = $urandom;
    endtask

    // Entered and left just after a rising edge with the stage in IDLE.
    // hit_at: ACCESS cycle (1-based) on which the cache answers; 0 or >WAIT_MAX means never.
    task automatic do_mem(input logic ren, input logic wen, input logic atom,
                          input logic [31:0] addr, input logic [31:0] wdat,
                          input int hit_at, input logic [31:0] rdata, input int stall);
        logic is_op;
        logic hit;
        is_op = ren | wen;
        hit = 1'b0;
        m_dREN = ren; m_dWEN = wen; m_datomic = atom; m_halt = 0;
        m_port_o = addr; m_rdat2 = wdat;
        dhit = 0; pipe_advance = 0; dmemload = $urandom;
        @(negedge CLK);
        check("idle_busy", mem_busy, (is_op && !exp_halt) ? 1 : 0);
        check("idle_ren", dmemREN, 0);
        @(posedge CLK); #1;
        if (!is_op || exp_halt) begin
            drive_nop();
            return;
        end
        if (addr[1:0] != 2'b00) begin
            exp_align = 1'b1;
            exp_dload = '0;
        end else begin
            for (int k = 1; k <= WAIT_MAX; k++) begin
                dhit = (k == hit_at);
                dmemload = dhit ? rdata : $urandom;
                @(negedge CLK);
                check("acc_ren", dmemREN, ren);
                check("acc_wen", dmemWEN, wen & ~ren);
                check("acc_atomic", datomic, atom);
                check("acc_addr", dmemaddr, addr);
                check("acc_store", dmemstore, wdat);
                check("acc_busy", mem_busy, 1);
                @(posedge CLK); #1;
                if (k == hit_at) begin
                    hit = 1'b1;
                    if (ren || atom) exp_dload = rdata;
                    break;
                end
            end
            if (!hit) begin
                exp_timeout = 1'b1;
                exp_dload = '0;
            end
            dhit = 0;
        end
        for (int s = 0; s <= stall; s++) begin
            pipe_advance = (s == stall);
            @(negedge CLK);
            check("done_ren", dmemREN, 0);
            check("done_wen", dmemWEN, 0);
            check("done_busy", mem_busy, 0);
            check("done_dload", m_dload, exp_dload);
            check("done_align", align_err, exp_align);
            check("done_timeout", mem_timeout, exp_timeout);
            @(posedge CLK); #1;
        end
        pipe_advance = 0;
        drive_nop();
    endtask

    initial begin
        int kind;
        logic [31:0] a;

        m_dREN = 1;
        #1 RST = 1;
        #2;
        check_all_zero("reset");
        m_dREN = 0;
        @(negedge CLK);
        RST = 0;
        @(posedge CLK); #1;

        // Plan 1: load with dhit on 2nd ACCESS cycle.
        do_mem(1, 0, 0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 0);
        // Plan 2: store with immediate dhit, downstream stalled 3 cycles.
        do_mem(0, 1, 0, 32'h80, 32'h12345678, 1, 32'hFFFF_FFFF, 3);
        // Plan 3: SC that fails.
        do_mem(0, 1, 1, 32'h100, 32'h1, 1, 32'h0, 0);
        // Non-memop adds no stall.
        do_mem(0, 0, 0, 32'h42, 32'h0, 1, 32'h0, 0);
        // Plan 4: misaligned load.
        do_mem(1, 0, 0, 32'h42, 32'h0, 1, 32'h5555_5555, 0);
        // Plan 5: cache never answers.
        do_mem(1, 0, 0, 32'h44, 32'h0, 0, 32'h0, 1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            case (kind)
                0: do_mem(0, 0, 0, a, $urandom, 1, $urandom, 0);
                1: do_mem(1, 0, 0, a, $urandom, $urandom_range(0, WAIT_MAX + 1), $urandom, $urandom_range(0, 2));
                2: do_mem(0, 1, 0, a, $urandom, $urandom_range(0, WAIT_MAX + 1), $urandom, $urandom_range(0, 2));
                3: do_mem(1, 0, 1, a, $urandom, $urandom_range(0, WAIT_MAX + 1), $urandom, $urandom_range(0, 2));
                4: do_mem(0, 1, 1, a, $urandom, $urandom_range(0, WAIT_MAX + 1), $urandom_range(0, 1), $urandom_range(0, 2));
                default: do_mem(1, 1, 0, a, $urandom, $urandom_range(0, WAIT_MAX + 1), $urandom, $urandom_range(0, 2));
            endcase
        end

        // Plan 6a: asynchronous reset in the middle of an access.
        m_dREN = 1; m_dWEN = 0; m_datomic = 0; m_port_o = 32'h200; dhit = 0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("pre_rst_ren", dmemREN, 1);
        #1 RST = 1;
        #1;
        check_all_zero("midrst");
        drive_nop();
        #1 RST = 0;
        exp_dload = '0; exp_align = 0; exp_timeout = 0;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("post_rst_ren", dmemREN, 0);
        check("post_rst_busy", mem_busy, 0);
        @(posedge CLK); #1;
        do_mem(1, 0, 0, 32'h300, 32'h0, 1, 32'hCAFE_F00D, 0);

        // Plan 6b: halt is sticky and blocks further requests.
        m_halt = 1;
        @(posedge CLK); #1;
        m_halt = 0;
        exp_halt = 1'b1;
        @(negedge CLK);
        check("halt_set", halt, 1);
        @(posedge CLK); #1;
        do_mem(1, 0, 0, 32'h400, 32'h0, 1, 32'h1234, 0);
        do_mem(0, 1, 0, 32'h404, 32'h9, 1, 32'h0, 0);
        @(negedge CLK);
        check("halt_sticky", halt, 1);
        check("halt_no_req", dmemREN | dmemWEN, 0);
        check("halt_dload", m_dload, exp_dload);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
